// File: rtl/sonic_ring_address_generator.sv
// Multi-channel ring-buffer address generator with round-robin burst grants.
// Optional per-channel beat counters are enabled by SONIC_ADDR_GEN_STATS_EN.
module sonic_ring_address_generator #(
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_CH = 2,
    parameter int CH_DEPTH = 4096,
    parameter int BURST_MAX = 8,
    localparam int LEN_W = $clog2(BURST_MAX + 1),
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req_valid,
    input  logic [NUM_CH*LEN_W-1:0] req_len,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [NUM_CH-1:0]       ch_clear,
    output logic                    addr_valid,
    input  logic                    addr_ready,
    output logic [ADDR_WIDTH-1:0]   addr_out,
    output logic [CH_W-1:0]         addr_ch,
    output logic                    addr_last,
    output logic [NUM_CH-1:0]       wrap_pulse
`ifdef SONIC_ADDR_GEN_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]    beat_count
`endif
);

    localparam int OFF_W = $clog2(CH_DEPTH);

    typedef enum logic [1:0] {IDLE, GRANT, BURST} state_t;

    state_t state, state_next;
    logic [CH_W-1:0] cur_ch, rr_ptr, pick;
    logic pick_found;
    int idx;
    logic [LEN_W-1:0] remaining, len_sel, len_clamped;
    logic [OFF_W-1:0] offset [NUM_CH];
    logic [NUM_CH-1:0] clr_pend, busy;
    logic beat;

    // Round-robin search starting at the pointer.
    always_comb begin
        pick = '0;
        pick_found = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!pick_found && req_valid[idx]) begin
                pick = CH_W'(idx);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        len_sel = req_len[int'(cur_ch)*LEN_W +: LEN_W];
        len_clamped = (len_sel > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : len_sel;
        for (int c = 0; c < NUM_CH; c++)
            busy[c] = (state != IDLE) && (int'(cur_ch) == c);
    end

    always_comb begin
        state_next = state;
        req_ready = '0;
        addr_valid = 1'b0;
        unique case (state)
            IDLE: if (pick_found) state_next = GRANT;
            GRANT: begin
                req_ready[cur_ch] = 1'b1;
                state_next = (len_sel == '0) ? IDLE : BURST;
            end
            BURST: begin
                addr_valid = 1'b1;
                if (addr_ready && remaining == LEN_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign beat = (state == BURST) && addr_ready;
    assign addr_last = (state == BURST) && (remaining == LEN_W'(1));
    assign addr_ch = cur_ch;
    assign addr_out = (ADDR_WIDTH'(cur_ch) << OFF_W) | ADDR_WIDTH'(offset[cur_ch]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cur_ch <= '0;
            rr_ptr <= '0;
            remaining <= '0;
            wrap_pulse <= '0;
            clr_pend <= '0;
            for (int c = 0; c < NUM_CH; c++) offset[c] <= '0;
        end else begin
            state <= state_next;
            wrap_pulse <= '0;
            if (state == IDLE && pick_found) cur_ch <= pick;
            if (state == GRANT) begin
                remaining <= len_clamped;
                rr_ptr <= (int'(cur_ch) == NUM_CH - 1) ? '0 : cur_ch + 1'b1;
            end
            if (beat) remaining <= remaining - 1'b1;
            // A clear on the active channel waits until its burst is over.
            for (int c = 0; c < NUM_CH; c++) begin
                if (beat && int'(cur_ch) == c) begin
                    offset[c] <= offset[c] + 1'b1;
                    if (offset[c] == '1) wrap_pulse[c] <= 1'b1;
                end else if (!busy[c] && (ch_clear[c] || clr_pend[c])) begin
                    offset[c] <= '0;
                end
                if (busy[c] && ch_clear[c]) clr_pend[c] <= 1'b1;
                else if (!busy[c]) clr_pend[c] <= 1'b0;
            end
        end
    end

`ifdef SONIC_ADDR_GEN_STATS_EN
    logic [31:0] beats [NUM_CH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) beats[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (beat && int'(cur_ch) == c) begin
                    if (beats[c] != '1) beats[c] <= beats[c] + 1'b1;
                end else if (!busy[c] && (ch_clear[c] || clr_pend[c])) begin
                    beats[c] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) beat_count[c*32 +: 32] = beats[c];
    end
`endif

endmodule

// File: tb/tb_sonic_ring_address_generator.sv
// Scoreboard bench for sonic_ring_address_generator: a ring/round-robin model
// predicts grants, beats and wrap pulses; a monitor compares them.
module tb_sonic_ring_address_generator;

    localparam int AW = 13;
    localparam int NC = 2;
    localparam int DEPTH = 4096;
    localparam int BMAX = 8;
    localparam int LW = 4;
    localparam int CW = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NC-1:0] req_valid = '0;
    logic [NC*LW-1:0] req_len = '0;
    logic [NC-1:0] req_ready;
    logic [NC-1:0] ch_clear = '0;
    logic addr_valid;
    logic addr_ready = 1'b1;
    logic [AW-1:0] addr_out;
    logic [CW-1:0] addr_ch;
    logic addr_last;
    logic [NC-1:0] wrap_pulse;
`ifdef SONIC_ADDR_GEN_STATS_EN
    logic [NC*32-1:0] beat_count;
`endif

    sonic_ring_address_generator dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_len(req_len),
        .req_ready(req_ready),
        .ch_clear(ch_clear),
        .addr_valid(addr_valid),
        .addr_ready(addr_ready),
        .addr_out(addr_out),
        .addr_ch(addr_ch),
        .addr_last(addr_last),
        .wrap_pulse(wrap_pulse)
`ifdef SONIC_ADDR_GEN_STATS_EN
        ,
        .beat_count(beat_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int ch;
        bit last;
        bit wrap;
    } beat_t;

    beat_t exp_beat[$];
    int exp_grant[$];
    int moff[NC];
    int mptr = 0;
    int total = 0;
    int bad = 0;
    bit rdy_rand = 1'b0;
    int stall_hold = 0;
    logic [NC-1:0] exp_wrap = '0;
    logic [NC-1:0] nw;
    beat_t b;
    int g;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: each channel is a ring of DEPTH words at base ch*DEPTH.
    function automatic void model_burst(input int ch, input int len);
        int eff;
        beat_t e;
        eff = (len > BMAX) ? BMAX : len;
        exp_grant.push_back(ch);
        for (int i = 0; i < eff; i++) begin
            e.addr = ch * DEPTH + moff[ch];
            e.ch = ch;
            e.last = (i == eff - 1);
            e.wrap = (moff[ch] == DEPTH - 1);
            exp_beat.push_back(e);
            moff[ch] = (moff[ch] + 1) % DEPTH;
        end
        mptr = (ch + 1) % NC;
    endfunction

    always @(negedge clk) begin
        if (stall_hold > 0) begin
            addr_ready = 1'b0;
            stall_hold--;
        end else begin
            addr_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            exp_wrap = '0;
        end else begin
            if (wrap_pulse != '0 || exp_wrap != '0)
                check("wrap_pulse", wrap_pulse, exp_wrap);
            nw = '0;
            if (req_ready != '0) begin
                if (exp_grant.size() == 0) begin
                    check("unexpected_grant", req_ready, 0);
                end else begin
                    g = exp_grant.pop_front();
                    check("grant", req_ready, 1 << g);
                end
            end
            if (addr_valid) begin
                if (exp_beat.size() == 0) begin
                    check("unexpected_beat", addr_valid, 0);
                end else begin
                    b = exp_beat[0];
                    check("addr_out", addr_out, b.addr);
                    check("addr_ch", addr_ch, b.ch);
                    check("addr_last", addr_last, b.last);
                    if (addr_ready) begin
                        void'(exp_beat.pop_front());
                        if (b.wrap) nw[b.ch] = 1'b1;
                    end
                end
            end
            exp_wrap = nw;
        end
    end

    task automatic do_round(input logic [NC-1:0] mask, input int l0, input int l1,
                            input int clr, input bit lat);
        int lens[NC];
        logic [NC-1:0] pend;
        int first;
        int start;
        bit done;
        lens[0] = l0;
        lens[1] = l1;
        first = -1;
        start = mptr;
        for (int i = 0; i < NC; i++) begin
            int c;
            c = (start + i) % NC;
            if (mask[c]) begin
                if (first < 0) first = c;
                model_burst(c, lens[c]);
            end
        end
        if (clr >= 0) moff[clr] = 0;
        req_len = {l1[LW-1:0], l0[LW-1:0]};
        req_valid = mask;
        pend = mask;
        done = 1'b0;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clk);
            if (lat && k == 1) check("lat_grant", req_ready, 1 << first);
            if (lat && k == 2) check("lat_first_beat", addr_valid, 1);
            ch_clear = '0;
            for (int i = 0; i < NC; i++) begin
                if (pend[i] && req_ready[i]) begin
                    pend[i] = 1'b0;
                    req_valid[i] = 1'b0;
                    if (clr == i) ch_clear[i] = 1'b1;
                end
            end
            if (pend == '0 && ch_clear == '0 && exp_grant.size() == 0 &&
                exp_beat.size() == 0 && !addr_valid)
                done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL round_timeout: pending=%0d beats_left=%0d", pend, exp_beat.size());
        end
        req_valid = '0;
        ch_clear = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_clear(input logic [NC-1:0] m);
        @(negedge clk);
        ch_clear = m;
        @(negedge clk);
        ch_clear = '0;
        for (int i = 0; i < NC; i++) if (m[i]) moff[i] = 0;
    endtask

    initial begin
        int rem;
        int m;
        int cl;
        bit granted;
        for (int i = 0; i < NC; i++) moff[i] = 0;
        repeat (2) @(negedge clk);
        check("rst_addr_valid", addr_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_addr_out", addr_out, 0);
        check("rst_wrap", wrap_pulse, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_round(2'b01, 4, 0, -1, 1'b1);
        repeat (2) do_round(2'b11, 2, 2, -1, 1'b0);

        fork
            do_round(2'b01, 6, 0, -1, 1'b0);
            begin
                for (int k = 0; k < 20 && !addr_valid; k++) @(negedge clk);
                stall_hold = 3;
            end
        join

        while (moff[1] != DEPTH - 2) begin
            rem = (DEPTH - 2 - moff[1] + DEPTH) % DEPTH;
            do_round(2'b10, 0, (rem > BMAX) ? BMAX : rem, -1, 1'b0);
        end
        do_round(2'b10, 0, 4, -1, 1'b0);

        do_round(2'b01, 0, 0, -1, 1'b0);
        do_round(2'b01, 15, 0, -1, 1'b0);

        idle_clear(2'b01);
        do_round(2'b01, 5, 0, -1, 1'b0);
        do_round(2'b01, 4, 0, 0, 1'b0);
        do_round(2'b01, 3, 0, -1, 1'b0);

        rdy_rand = 1'b1;
        for (int r = 0; r < 150; r++) begin
            m = $urandom_range(1, 3);
            cl = -1;
            if ($urandom_range(0, 3) == 0) cl = m[0] ? 0 : 1;
            do_round(m[NC-1:0], $urandom_range(0, 15), $urandom_range(0, 15), cl, 1'b0);
            if ($urandom_range(0, 7) == 0) idle_clear(NC'($urandom_range(1, 3)));
        end

        rdy_rand = 1'b0;
        @(negedge clk);
        model_burst(0, 8);
        req_len = {4'd0, 4'd8};
        req_valid = 2'b01;
        granted = 1'b0;
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            if (req_ready[0]) granted = 1'b1;
        end
        req_valid = '0;
        check("mid_burst_grant", granted, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_beat.delete();
        exp_grant.delete();
        for (int i = 0; i < NC; i++) moff[i] = 0;
        mptr = 0;
        @(negedge clk);
        check("rst_mid_valid", addr_valid, 0);
        check("rst_mid_addr", addr_out, 0);
        check("rst_mid_last", addr_last, 0);
        check("rst_mid_ready", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        do_round(2'b01, 3, 0, -1, 1'b1);
        do_round(2'b10, 0, 2, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
